// File: rtl/reg_pipe_if.sv
// Valid/ready bus bundle for reg_pipe: upstream push side, downstream pop side, occupancy.
interface reg_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    // Producer/consumer environment around the pipeline
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    // The pipeline itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );
endinterface

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and occupancy count.
module reg_pipe #(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    reg_pipe_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Elaboration-time parameter guard
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("reg_pipe: WIDTH must be at least 1");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("reg_pipe: DEPTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_ld;
    logic [DEPTH-1:0] w_vin;
    logic [WIDTH-1:0] w_din [DEPTH];
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Load enables: a stage may load when it or any stage downstream of it can vacate.
    // Built as a running OR from the output end so no signal feeds back on itself.
    always_comb begin
        logic w_acc;
        w_ld  = '0;
        w_acc = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_acc   = w_acc | ~r_valid[i];
            w_ld[i] = w_acc;
        end
    end

    assign w_in_ready = w_ld[0] & ~flush;
    assign w_in_xfer  = bus.in_valid & w_in_ready;
    assign w_out_xfer = r_valid[DEPTH-1] & bus.out_ready;

    // Per-stage incoming valid/data: stage 0 from the bus, others from the stage behind.
    always_comb begin
        w_vin    = '0;
        w_vin[0] = w_in_xfer;
        w_din[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_vin[i] = r_valid[i-1];
            w_din[i] = r_data[i-1];
        end
    end

    // Valid bits: cleared by reset or flush, otherwise shifted where the stage loads.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ld[i]) begin
                    r_valid[i] <= w_vin[i];
                end
            end
        end
    end

    // Data registers: only a valid word overwrites; bubbles and flush leave data in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VALUE;
            end
        end else if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ld[i] && w_vin[i]) begin
                    r_data[i] <= w_din[i];
                end
            end
        end
    end

    // Occupancy tracks accepted minus delivered words.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid[DEPTH-1];
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.count     = r_count;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed self-checking bench for reg_pipe (WIDTH=32, DEPTH=4, RESET_VALUE=0).
module tb_reg_pipe;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    logic flush;

    int n_checks = 0;
    int n_fail   = 0;

    reg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reg_pipe #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (32'h0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    initial begin
        int got;
        bit pending;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held for two edges
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data",  bus.out_data,       32'd0);
        check_eq("rst_count",     32'(bus.count),     32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Streaming 1..8 with out_ready high: first word visible 4 cycles after presentation
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (k < 8);
            bus.in_data   = 32'(k + 1);
            #1;
            if (k < 8) check_eq("str_in_ready", 32'(bus.in_ready), 32'd1);
            if (k >= 4 && k <= 11) begin
                check_eq("str_out_valid", 32'(bus.out_valid), 32'd1);
                check_eq("str_out_data",  bus.out_data,       32'(k - 3));
            end else begin
                check_eq("str_out_idle", 32'(bus.out_valid), 32'd0);
            end
        end

        // Backpressure: fill with 10..13, 14 must wait
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'(10 + k);
            #1;
            check_eq("bp_count",    32'(bus.count),    32'(k));
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'(k < 4));
        end
        check_eq("bp_head", bus.out_data, 32'd10);

        // Release backpressure and drain in order
        got     = 0;
        pending = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (!pending) bus.in_valid = 1'b0;
            #1;
            if (bus.in_valid && bus.in_ready) pending = 1'b0;
            if (bus.out_valid) begin
                check_eq("bp_data", bus.out_data, 32'(10 + got));
                got++;
            end
            if (got == 5) break;
        end
        check_eq("bp_total", 32'(got), 32'd5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check_eq("bp_empty_valid", 32'(bus.out_valid), 32'd0);
        check_eq("bp_empty_count", 32'(bus.count),     32'd0);

        // Bubble collapse: 5, two idle cycles, 6, all under backpressure
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = (k == 0) || (k == 3);
            bus.in_data   = (k == 0) ? 32'd5 : 32'd6;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check_eq("bc_count",     32'(bus.count),     32'd2);
        check_eq("bc_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("bc_out_data",  bus.out_data,       32'd5);
        check_eq("bc_valid_map", 32'(dut.r_valid),   32'b1100);
        check_eq("bc_stage2",    dut.r_data[2],      32'd6);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check_eq("bc_drain0", bus.out_data, 32'd5);
        @(negedge clk);
        #1;
        check_eq("bc_drain1_v", 32'(bus.out_valid), 32'd1);
        check_eq("bc_drain1",   bus.out_data,       32'd6);
        @(negedge clk);
        #1;
        check_eq("bc_drained", 32'(bus.count), 32'd0);

        // Flush a full pipe of 20..23
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'(20 + k);
        end
        @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd77;
        #1;
        check_eq("fl_count_pre", 32'(bus.count),    32'd4);
        check_eq("fl_in_ready",  32'(bus.in_ready), 32'd0);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("fl_count",     32'(bus.count),     32'd0);
        check_eq("fl_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("fl_in_ready2", 32'(bus.in_ready),  32'd1);
        check_eq("fl_data_kept", bus.out_data,       32'd20);
        @(negedge clk);
        #1;
        check_eq("fl_no_accept", 32'(bus.count), 32'd0);

        // Mid-stream reset with 31..33 in flight, then 99 is the first word out
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'(31 + k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        check_eq("mr_count_pre", 32'(bus.count), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mr_count",     32'(bus.count),     32'd0);
        check_eq("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mr_out_data",  bus.out_data,       32'd0);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (c == 0);
            bus.in_data   = 32'd99;
            #1;
            if (c == 4) begin
                check_eq("mr_first_valid", 32'(bus.out_valid), 32'd1);
                check_eq("mr_first_data",  bus.out_data,       32'd99);
            end else begin
                check_eq("mr_wait_valid", 32'(bus.out_valid), 32'd0);
                check_eq("mr_wait_data",  bus.out_data,       32'd0);
            end
        end
        @(negedge clk);
        #1;
        check_eq("mr_done", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
